// File: rtl/register_pkg.sv
// ---------------------------------------------------------------------------
// reg_pkg : shared constants and types for the storage register slice.
//   DEFAULT_REG_WIDTH : default data width of the register (4 bits).
//   data_t            : data word at the default width.
// ---------------------------------------------------------------------------
package reg_pkg;

    localparam int DEFAULT_REG_WIDTH = 4;

    typedef logic [DEFAULT_REG_WIDTH-1:0] data_t;

endpackage : reg_pkg

// File: rtl/register_if.sv
// ---------------------------------------------------------------------------
// register_if : data bundle around one register stage.
//   d_in  : data presented to the stage.
//   d_out : registered data coming back from the stage.
// Modports:
//   master : drives d_in, observes d_out (upstream / bench side).
//   slave  : observes d_in, drives d_out (register side).
// ---------------------------------------------------------------------------
interface register_if
    import reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_REG_WIDTH
);

    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;

    modport master (
        output d_in,
        input  d_out
    );

    modport slave (
        input  d_in,
        output d_out
    );

endinterface : register_if

// File: rtl/register_dff.sv
// ---------------------------------------------------------------------------
// dff_async_r : single-bit D flip-flop, asynchronous active-high reset.
//   clk     : rising-edge clock.
//   reset   : asynchronous, active-high; forces q to rst_val immediately.
//   rst_val : value loaded into q while reset is high.
//   d       : data sampled on each rising clk edge while reset is low.
//   q       : registered output.
// ---------------------------------------------------------------------------
module dff_async_r (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    // Reset is in the sensitivity list so it acts without a clock edge and
    // overrides any capture that lands in the same timestep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= rst_val;
        else       q <= d;
    end

endmodule : dff_async_r

// File: rtl/register.sv
// ---------------------------------------------------------------------------
// register : parameterised edge-triggered storage register.
//   Loads d_in on every rising clk edge (no enable, no handshake) and holds
//   it on d_out until the next edge. An asynchronous active-high reset
//   forces d_out to RESET_VAL for as long as it is asserted.
// Parameters:
//   WIDTH     : data width (>= 1), default 4.
//   RESET_VAL : value of d_out while reset is high, default all zeros.
// Ports (positional order clk, reset, d_in, d_out):
//   clk   : rising-edge clock.
//   reset : asynchronous, active-high reset.
//   d_in  : data to capture.
//   d_out : registered data.
// ---------------------------------------------------------------------------
module register
    import reg_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_REG_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    // One flop per bit, each with its own reset value so arbitrary
    // RESET_VAL patterns need no extra muxing. No X masking: an unknown
    // d_in bit propagates straight to the matching d_out bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_async_r u_dff (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RESET_VAL[i]),
            .d       (d_in[i]),
            .q       (d_out[i])
        );
    end

endmodule : register

// File: tb/tb_register.sv
// ---------------------------------------------------------------------------
// tb_register : self-checking bench for register (WIDTH = 4, RESET_VAL = 0).
// ---------------------------------------------------------------------------
module tb_register;
    import reg_pkg::*;

    localparam int    W  = DEFAULT_REG_WIDTH;
    localparam data_t RV = '0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    register_if #(.WIDTH(W)) bus ();

    register #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (bus.d_in),
        .d_out (bus.d_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    // Reference model: d_out is the d_in seen at the latest clock edge with
    // reset low, unless reset is high now or was raised at/after that edge.
    data_t cap_val;
    time   cap_t   = 0;
    bit    cap_ok  = 1'b0;
    time   rst_t   = 0;

    always @(posedge clk) begin
        if (!reset) begin
            cap_val = bus.d_in;
            cap_t   = $time;
            cap_ok  = 1'b1;
        end
    end

    always @(posedge reset) rst_t = $time;

    function automatic data_t model_out();
        if (reset || !cap_ok || rst_t >= cap_t) return RV;
        return cap_val;
    endfunction

    task automatic chk(input string name, input data_t act, input data_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: d_out=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, mid-cycle where d_out is stable.
    always @(negedge clk) begin
        if (!done) chk("model", bus.d_out, model_out());
    end

    initial begin
        bus.d_in = 4'b0000;
        repeat (2) @(negedge clk);
        chk("reset_state", bus.d_out, 4'b0000);

        // Release and load a first value.
        reset    = 1'b0;
        bus.d_in = 4'b1010;
        @(posedge clk); #1;
        chk("load_1010", bus.d_out, 4'b1010);

        // Reset asserted between edges: immediate, and held across 3 edges.
        @(negedge clk); #2;
        reset = 1'b1;
        #1 chk("async_assert", bus.d_out, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("reset_hold", bus.d_out, 4'b0000);
        end

        // Mid-cycle release: no change until the next edge.
        @(negedge clk);
        bus.d_in = 4'b0001;
        #2 reset = 1'b0;
        #1 chk("release_no_change", bus.d_out, 4'b0000);
        @(posedge clk); #1;
        chk("first_capture", bus.d_out, 4'b0001);

        // Incrementing sweep, new value 5 ns before each edge.
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            bus.d_in = data_t'(v);
            @(posedge clk); #1;
            chk("sweep", bus.d_out, data_t'(v));
        end
        chk("sweep_end", bus.d_out, 4'b1111);

        // Short reset pulse mid-operation.
        @(negedge clk);
        bus.d_in = 4'b0110;
        @(posedge clk); #1;
        chk("preload_0110", bus.d_out, 4'b0110);
        @(negedge clk);
        bus.d_in = 4'b0111;
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        #0 chk("pulse_clear", bus.d_out, 4'b0000);
        @(posedge clk); #1;
        chk("after_pulse", bus.d_out, 4'b0111);

        // Reset rising in the same timestep as a clock edge wins.
        @(negedge clk);
        bus.d_in = 4'b1111;
        @(posedge clk);
        reset = 1'b1;
        #1 chk("coincident_reset", bus.d_out, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_coincident", bus.d_out, 4'b1111);

        // d_in toggling between edges does not reach d_out.
        @(negedge clk);
        bus.d_in = 4'b0011;
        #1 bus.d_in = 4'b1100;
        #1 bus.d_in = 4'b0011;
        #1 chk("hold_between_edges", bus.d_out, 4'b1111);
        @(posedge clk); #1;
        chk("value_at_edge", bus.d_out, 4'b0011);

        // Randomized phase: random data every cycle, occasional reset pulses.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #1 bus.d_in = data_t'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) begin
                #1 reset = 1'b1;
                #1 chk("rand_pulse", bus.d_out, RV);
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk); #1;
                    chk("rand_pulse_hold", bus.d_out, RV);
                    @(negedge clk);
                end
                #1 reset = 1'b0;
            end
        end

        @(negedge clk);
        done = 1'b1;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected completion before t=%0t", $time);
        $fatal(1);
    end

endmodule : tb_register
